uart_line_echo: RTL and testbench

Line-buffered echo stage between the UART receiver output and the UART transmitter input. Collects received bytes into a line buffer until a terminator byte arrives or the buffer fills. Then replays the whole line, terminator included, to the transmitter one byte at a time, pacing on the transmitter's busy flag. Replaces raw byte echo so that output is emitted line by line.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/line_ram.sv | 57 +++++
 rtl/uart_line_echo.sv | 170 +++++++++++++++++
 tb/tb_uart_line_echo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and character constants for the UART line echo stage
//
// Purpose: FSM state type for uart_line_echo and the ASCII control
//          characters it recognises.
// Ports:   none (package).

package uart_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-clock simple dual-port line buffer memory
//
// Purpose: WIDTH x DEPTH storage with a synchronous write port and a
//          registered read port (data appears the cycle after rd_en).
//          The read register holds its value until the next rd_en.
// Ports:
//   clk      in   clock
//   rst_in   in   synchronous active-high reset (clears the read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe
//   rd_addr  in   read address
//   rd_data  out  registered read data

module line_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_line_echo.sv
// rtl/uart_line_echo.sv - line-buffered echo between UART receiver and transmitter
//
// Purpose: collects received characters until TERM_CHAR arrives or the
//          buffer fills, then replays the whole line (terminator included)
//          to the transmitter one character at a time, paced by tx_busy_in.
// Build option: define UART_LINE_ECHO_BACKSPACE_EN to make 8'h08 / 8'h7F
//          erase the previous character instead of being stored.
// Ports:
//   clk           in   clock
//   rst_in        in   synchronous active-high reset
//   rx_data_in    in   received character
//   rx_dv_in      in   one-cycle strobe for rx_data_in
//   tx_data_out   out  character for the transmitter
//   tx_dv_out     out  one-cycle start strobe for the transmitter
//   tx_busy_in    in   transmitter busy (rises the cycle after tx_dv_out)
//   line_len_out  out  characters currently held
//   flushing_out  out  high while a line is being replayed
//   drop_out      out  one-cycle pulse: a received character was discarded

module uart_line_echo
    import uart_pkg::*;
#(
    parameter int                   DATA_BITS  = 8,
    parameter int                   LINE_DEPTH = 64,
    parameter logic [DATA_BITS-1:0] TERM_CHAR  = CHAR_CR
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic [DATA_BITS-1:0]          rx_data_in,
    input  logic                          rx_dv_in,
    output logic [DATA_BITS-1:0]          tx_data_out,
    output logic                          tx_dv_out,
    input  logic                          tx_busy_in,
    output logic [$clog2(LINE_DEPTH):0]   line_len_out,
    output logic                          flushing_out,
    output logic                          drop_out
);

    localparam int            AW       = $clog2(LINE_DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LINE_DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          guard_q, guard_d;

    logic                 wr_en;
    logic                 rd_en;
    logic                 drop;
    logic                 is_erase;
    logic [DATA_BITS-1:0] rd_data;

`ifdef UART_LINE_ECHO_BACKSPACE_EN
    assign is_erase = (rx_data_in == DATA_BITS'(CHAR_BS)) ||
                      (rx_data_in == DATA_BITS'(CHAR_DEL));
`else
    assign is_erase = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        guard_d  = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        drop     = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (rx_dv_in) begin
                    if (is_erase) begin
                        if (count_q != '0) begin
                            wr_ptr_d = wr_ptr_q - AW'(1);
                            count_d  = count_q - CW'(1);
                        end else begin
                            drop = 1'b1;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                        // A terminator landing as the last free slot is one flush.
                        if ((rx_data_in == TERM_CHAR) || (count_d == FULL_CNT)) begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end

            ST_LOAD: begin
                rd_en   = 1'b1;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                guard_d  = 1'b1;
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                // guard_q marks the first WAIT cycle, before the transmitter
                // has had a chance to raise busy.
                if (!guard_q && !tx_busy_in) begin
                    // rd_ptr has wrapped to 0 after a full line; the low bits
                    // of count are 0 then too, so the narrow compare is exact.
                    if (rd_ptr_q == count_q[AW-1:0]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                        state_d  = ST_FILL;
                    end else begin
                        state_d  = ST_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (rx_dv_in && (state_q != ST_FILL)) begin
            drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q  <= ST_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            guard_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            guard_q  <= guard_d;
        end
    end

    line_ram #(
        .WIDTH (DATA_BITS),
        .DEPTH (LINE_DEPTH)
    ) u_line_ram (
        .clk     (clk),
        .rst_in  (rst_in),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Strobes are masked by reset so an abandoned line cannot start the
    // transmitter or report a drop while reset is asserted.
    assign tx_data_out  = rd_data;
    assign tx_dv_out    = (state_q == ST_SEND) && !rst_in;
    assign drop_out     = drop && !rst_in;
    assign flushing_out = (state_q != ST_FILL);
    assign line_len_out = count_q;

endmodule

// File: tb/tb_uart_line_echo.sv
// tb/tb_uart_line_echo.sv - self-checking bench for uart_line_echo

`timescale 1ns/1ps

module tb_uart_line_echo;

`ifdef UART_LINE_ECHO_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_in;
    logic [7:0] rx_data_in;
    logic       rx_dv_in;
    logic [7:0] tx_data_out;
    logic       tx_dv_out;
    logic       tx_busy_in = 1'b0;
    logic [6:0] line_len_out;
    logic       flushing_out;
    logic       drop_out;

    always #5 clk = ~clk;

    uart_line_echo #(
        .DATA_BITS  (8),
        .LINE_DEPTH (64),
        .TERM_CHAR  (8'h0D)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .rx_data_in   (rx_data_in),
        .rx_dv_in     (rx_dv_in),
        .tx_data_out  (tx_data_out),
        .tx_dv_out    (tx_dv_out),
        .tx_busy_in   (tx_busy_in),
        .line_len_out (line_len_out),
        .flushing_out (flushing_out),
        .drop_out     (drop_out)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    int drops_total = 0;
    int last_rx_cyc = 0;
    logic [7:0] got[$];
    int         dv_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_dv_out) begin
            got.push_back(tx_data_out);
            dv_cyc.push_back(cyc);
            tests++;
            if (tx_busy_in) begin
                fails++;
                $display("FAIL tx_dv_while_busy: got busy=1 expected busy=0 at cycle %0d", cyc);
            end
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy_in = (busy_cnt > 0);
        if (drop_out) drops_total++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data_in  = b;
        rx_dv_in    = 1'b1;
        last_rx_cyc = cyc;
        @(posedge clk); #1;
        rx_dv_in    = 1'b0;
    endtask

    task automatic wait_flush(input string name);
        int n;
        n = 0;
        while (!flushing_out && n < 4) begin @(negedge clk); n++; end
        check({name, " flush_start"}, int'(flushing_out), 1);
        n = 0;
        while (flushing_out && n < 5000) begin @(negedge clk); n++; end
        check({name, " flush_end"}, int'(flushing_out), 0);
    endtask

    task automatic wait_got(input int k, input string name);
        int n;
        n = 0;
        while (got.size() < k && n < 300) begin @(negedge clk); n++; end
        check({name, " echo_seen"}, int'(got.size() >= k), 1);
    endtask

    function automatic int exp_gap(input int bl);
        return ((bl > 2) ? bl : 2) + 2;
    endfunction

    // One line from a packed byte string; byte i sits at [8*i +: 8].
    task automatic run_case(input string name, input logic [63:0] in_b, input int n,
                            input logic [63:0] ex_b, input int en, input int ex_drops);
        int gbase, dbase;
        gbase = got.size();
        dbase = drops_total;
        for (int i = 0; i < n; i++) send_byte(in_b[8*i +: 8]);
        wait_flush(name);
        check({name, " echo_count"}, got.size() - gbase, en);
        for (int i = 0; i < en; i++) begin
            if (gbase + i < got.size())
                check($sformatf("%s byte%0d", name, i), int'(got[gbase+i]), int'(ex_b[8*i +: 8]));
        end
        if (got.size() > gbase)
            check({name, " first_latency"}, dv_cyc[gbase] - last_rx_cyc, 2);
        for (int i = gbase + 1; i < got.size(); i++)
            check($sformatf("%s gap%0d", name, i - gbase), dv_cyc[i] - dv_cyc[i-1], exp_gap(busy_len));
        check({name, " drops"}, drops_total - dbase, ex_drops);
        check({name, " len_after"}, int'(line_len_out), 0);
    endtask

    typedef struct packed {
        logic [63:0] in_b;
        logic [3:0]  n;
        logic [63:0] ex_b;
        logic [3:0]  en;
        logic [3:0]  drops;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gbase, dbase, len, exp_drops, r;
        logic [7:0] b;
        logic [7:0] mline[$];
        logic [7:0] exp_q[$];
        bit flushed;

        vecs[0] = '{64'h0D4241,     4'd3, 64'h0D4241, 4'd3, 4'd0};
        vecs[1] = '{64'h0D,         4'd1, 64'h0D,     4'd1, 4'd0};
        vecs[2] = '{64'h0D58,       4'd2, 64'h0D58,   4'd2, 4'd0};
        vecs[3] = '{64'h0D0A61,     4'd3, 64'h0D0A61, 4'd3, 4'd0};
        if (BS_EN) begin
            vecs[4] = '{64'h0D43084241, 4'd5, 64'h0D4341, 4'd3, 4'd0};
            vecs[5] = '{64'h0D08,       4'd2, 64'h0D,     4'd1, 4'd1};
            vecs[6] = '{64'h0D7F51,     4'd3, 64'h0D,     4'd1, 4'd0};
        end else begin
            vecs[4] = '{64'h0D43084241, 4'd5, 64'h0D43084241, 4'd5, 4'd0};
            vecs[5] = '{64'h0D08,       4'd2, 64'h0D08,       4'd2, 4'd0};
            vecs[6] = '{64'h0D7F51,     4'd3, 64'h0D7F51,     4'd3, 4'd0};
        end

        rst_in     = 1'b1;
        rx_dv_in   = 1'b0;
        rx_data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        check("reset tx_dv",    int'(tx_dv_out),    0);
        check("reset flushing", int'(flushing_out), 0);
        check("reset len",      int'(line_len_out), 0);
        check("reset drop",     int'(drop_out),     0);
        check("reset tx_data",  int'(tx_data_out),  0);

        busy_len = 10;
        foreach (vecs[i])
            run_case($sformatf("vec%0d", i), vecs[i].in_b, int'(vecs[i].n),
                     vecs[i].ex_b, int'(vecs[i].en), int'(vecs[i].drops));

        // Auto-flush on a full buffer; 0x20.. avoids CR/BS/DEL.
        busy_len = 2;
        gbase = got.size();
        for (int i = 0; i < 63; i++) send_byte(8'(8'h20 + i));
        check("full len63", int'(line_len_out), 63);
        check("full not_flushing", int'(flushing_out), 0);
        send_byte(8'h5F);
        wait_flush("full");
        check("full count", got.size() - gbase, 64);
        if (got.size() > gbase) check("full latency", dv_cyc[gbase] - last_rx_cyc, 2);
        for (int i = 0; i < 64; i++)
            if (gbase + i < got.size())
                check($sformatf("full byte%0d", i), int'(got[gbase+i]), 8'h20 + i);
        check("full len_after", int'(line_len_out), 0);

        // Character arriving during WAIT is dropped in the same cycle.
        busy_len = 10;
        gbase = got.size();
        dbase = drops_total;
        send_byte(8'h58);
        send_byte(8'h0D);
        wait_got(gbase + 1, "drop");
        repeat (2) @(negedge clk);
        send_byte(8'h55);
        check("drop pulse", drops_total - dbase, 1);
        wait_flush("drop");
        check("drop count", got.size() - gbase, 2);
        if (got.size() >= gbase + 2) begin
            check("drop byte0", int'(got[gbase]),   8'h58);
            check("drop byte1", int'(got[gbase+1]), 8'h0D);
        end
        check("drop len_after", int'(line_len_out), 0);

        // Reset in the middle of a replay.
        busy_len = 4;
        gbase = got.size();
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
        send_byte(8'h0D);
        wait_got(gbase + 2, "rst");
        @(posedge clk); #1 rst_in = 1'b1;
        @(posedge clk); #1 rst_in = 1'b0;
        check("rst flushing", int'(flushing_out), 0);
        check("rst len",      int'(line_len_out), 0);
        check("rst tx_data",  int'(tx_data_out),  0);
        repeat (60) @(negedge clk);
        check("rst no_more_tx", got.size() - gbase, 2);
        run_case("rst_recover", 64'h0D5A, 2, 64'h0D5A, 2, 0);

        // Randomized lines against a queue-based line editor model.
        for (int ln = 0; ln < 12; ln++) begin
            busy_len = $urandom_range(6, 1);
            gbase = got.size();
            dbase = drops_total;
            exp_q.delete();
            mline.delete();
            exp_drops = 0;
            len = $urandom_range(70, 1);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(15, 0);
                if (k == len - 1) b = 8'h0D;
                else if (r == 0)  b = 8'h08;
                else if (r == 1)  b = 8'h0D;
                else              b = 8'($urandom_range(255, 0));
                send_byte(b);
                flushed = 1'b0;
                if (BS_EN && (b == 8'h08 || b == 8'h7F)) begin
                    if (mline.size() > 0) void'(mline.pop_back());
                    else exp_drops++;
                end else begin
                    mline.push_back(b);
                    if (b == 8'h0D || mline.size() == 64) begin
                        flushed = 1'b1;
                        foreach (mline[j]) exp_q.push_back(mline[j]);
                        mline.delete();
                    end
                end
                if (flushed) wait_flush($sformatf("rand%0d", ln));
                else check($sformatf("rand%0d len", ln), int'(line_len_out), mline.size());
            end
            check($sformatf("rand%0d count", ln), got.size() - gbase, exp_q.size());
            for (int j = 0; j < exp_q.size(); j++)
                if (gbase + j < got.size())
                    check($sformatf("rand%0d byte%0d", ln, j), int'(got[gbase+j]), int'(exp_q[j]));
            check($sformatf("rand%0d drops", ln), drops_total - dbase, exp_drops);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
